// File: rtl/keypad_panel_link.sv
// keypad_panel_link: panel end of the alarm controller link.
// Status frame receiver, link watchdog and buffered key digit sender.
module keypad_panel_link #(
  parameter int FRAME_BITS   = 4,
  parameter int LINK_TIMEOUT = 64,
  parameter int KB_GAP       = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       STATUS_OUT,
  input  logic       STATUS_SEND,
  output logic       ARMED,
  output logic       ALARM,
  output logic       SENSOR1,
  output logic       SENSOR2,
  output logic       STATUS_VALID,
  output logic       LINK_OK,
  input  logic [1:0] KEY_CODE,
  input  logic       KEY_VALID,
  output logic       KEY_READY,
  output logic       KEY_OVF,
  input  logic       KEY_OVF_CLR,
  output logic [1:0] KB_IN,
  output logic       KB_RECV
);

  localparam int CW = $clog2(FRAME_BITS + 1);
  localparam int LW = $clog2(LINK_TIMEOUT + 1);
  localparam int GW = $clog2(KB_GAP + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] BIT_LAST = CW'(FRAME_BITS - 1);
  localparam logic [LW-1:0] LINK_MAX = LW'(LINK_TIMEOUT);
  localparam logic [GW-1:0] GAP_LAST = GW'(KB_GAP - 1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);

  localparam logic RX_IDLE  = 1'b0;
  localparam logic RX_SHIFT = 1'b1;

  localparam logic [1:0] TX_IDLE = 2'd0;
  localparam logic [1:0] TX_SEND = 2'd1;
  localparam logic [1:0] TX_GAP  = 2'd2;

  // receive path state
  logic                  rx_state_q, rx_state_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-2:0] shift_q, shift_d;
  logic [3:0]            flags_q, flags_d;
  logic                  status_valid_q, status_valid_d;
  logic [FRAME_BITS-1:0] frame_w;
  logic                  rx_last, rx_mid;

  // link watchdog state
  logic [LW-1:0] link_cnt_q, link_cnt_d;
  logic          seen_q, seen_d;

  // key buffer state
  logic [1:0]    mem_q [FIFO_DEPTH];
  logic [1:0]    mem_d [FIFO_DEPTH];
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          full, empty;
  logic          push, pop;
  logic          avail;
  logic [1:0]    head;

  // transmit path state
  logic [1:0]    tx_q, tx_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [1:0]    kb_in_q, kb_in_d;
  logic          can_send, tx_go;

  assign frame_w = {shift_q, STATUS_OUT};
  assign rx_last = (rx_state_q == RX_SHIFT)
                && (bit_cnt_q == BIT_LAST);
  assign rx_mid  = (rx_state_q == RX_SHIFT)
                && (bit_cnt_q != BIT_LAST);

  // frame deserializer; a new start marker always restarts the count
  always_comb begin
    rx_state_d     = rx_state_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    flags_d        = flags_q;
    status_valid_d = 1'b0;
    unique case (1'b1)
      STATUS_SEND: begin
        rx_state_d = RX_SHIFT;
        bit_cnt_d  = '0;
      end
      (!STATUS_SEND && rx_last): begin
        flags_d        = frame_w[3:0];
        status_valid_d = 1'b1;
        rx_state_d     = RX_IDLE;
        bit_cnt_d      = '0;
      end
      (!STATUS_SEND && rx_mid): begin
        shift_d   = frame_w[FRAME_BITS-2:0];
        bit_cnt_d = bit_cnt_q + CW'(1);
      end
      default: ;
    endcase
  end

  // receive registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_state_q     <= RX_IDLE;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      flags_q        <= '0;
      status_valid_q <= 1'b0;
    end else begin
      rx_state_q     <= rx_state_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      flags_q        <= flags_d;
      status_valid_q <= status_valid_d;
    end
  end

  // link age: zero on a completed frame, saturating otherwise
  always_comb begin
    seen_d = seen_q | status_valid_d;
    if (status_valid_d)
      link_cnt_d = '0;
    else if (link_cnt_q == LINK_MAX)
      link_cnt_d = link_cnt_q;
    else
      link_cnt_d = link_cnt_q + LW'(1);
  end

  // link watchdog registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      link_cnt_q <= '0;
      seen_q     <= 1'b0;
    end else begin
      link_cnt_q <= link_cnt_d;
      seen_q     <= seen_d;
    end
  end

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);
  assign push  = KEY_VALID && !full;
  assign avail = !empty || push;
  assign head  = empty ? KEY_CODE : mem_q[rd_q];

  // key buffer; an empty buffer forwards the incoming digit directly
  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    ovf_d   = ovf_q;
    if (push) begin
      mem_d[wr_q] = KEY_CODE;
      wr_d        = wr_q + AW'(1);
    end
    if (pop)
      rd_d = rd_q + AW'(1);
    count_d = count_q
            + {{AW{1'b0}}, push}
            - {{AW{1'b0}}, pop};
    if (KEY_OVF_CLR)
      ovf_d = 1'b0;
    if (KEY_VALID && full)
      ovf_d = 1'b1;
  end

  // key buffer registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mem_q   <= '{default: '0};
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign can_send = (tx_q == TX_IDLE)
                 || ((tx_q == TX_GAP)
                 && (gap_q == GAP_LAST));
  assign tx_go    = can_send && avail;
  assign pop      = tx_go;

  // digit sender: one strobe then a fixed quiet gap
  always_comb begin
    tx_d    = tx_q;
    gap_d   = gap_q;
    kb_in_d = kb_in_q;
    unique case (1'b1)
      tx_go: begin
        tx_d    = TX_SEND;
        kb_in_d = head;
      end
      (!tx_go && tx_q == TX_SEND): begin
        tx_d  = TX_GAP;
        gap_d = '0;
      end
      (!tx_go && tx_q == TX_GAP
        && gap_q == GAP_LAST): begin
        tx_d = TX_IDLE;
      end
      (!tx_go && tx_q == TX_GAP
        && gap_q != GAP_LAST): begin
        gap_d = gap_q + GW'(1);
      end
      default: ;
    endcase
  end

  // transmit registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tx_q    <= TX_IDLE;
      gap_q   <= '0;
      kb_in_q <= '0;
    end else begin
      tx_q    <= tx_d;
      gap_q   <= gap_d;
      kb_in_q <= kb_in_d;
    end
  end

  assign ARMED        = flags_q[3];
  assign ALARM        = flags_q[2];
  assign SENSOR1      = flags_q[1];
  assign SENSOR2      = flags_q[0];
  assign STATUS_VALID = status_valid_q;
  assign LINK_OK      = seen_q
                     && (link_cnt_q < LINK_MAX);
  assign KEY_READY    = !full;
  assign KEY_OVF      = ovf_q;
  assign KB_IN        = kb_in_q;
  assign KB_RECV      = (tx_q == TX_SEND);

endmodule

// File: tb/tb_keypad_panel_link.sv
// tb_keypad_panel_link: bench for the panel link.
// Frame/queue level reference plus directed literal checks.
module tb_keypad_panel_link;

  localparam int FB    = 4;
  localparam int TO    = 64;
  localparam int GAP   = 2;
  localparam int DEPTH = 4;

  logic       CLK = 0;
  logic       RST_N = 0;
  logic       STATUS_OUT = 0;
  logic       STATUS_SEND = 0;
  logic [1:0] KEY_CODE = 0;
  logic       KEY_VALID = 0;
  logic       KEY_OVF_CLR = 0;
  logic       ARMED, ALARM, SENSOR1, SENSOR2;
  logic       STATUS_VALID, LINK_OK;
  logic       KEY_READY, KEY_OVF;
  logic [1:0] KB_IN;
  logic       KB_RECV;

  keypad_panel_link #(
    .FRAME_BITS(FB), .LINK_TIMEOUT(TO),
    .KB_GAP(GAP), .FIFO_DEPTH(DEPTH)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .STATUS_OUT(STATUS_OUT),
    .STATUS_SEND(STATUS_SEND),
    .ARMED(ARMED), .ALARM(ALARM),
    .SENSOR1(SENSOR1), .SENSOR2(SENSOR2),
    .STATUS_VALID(STATUS_VALID),
    .LINK_OK(LINK_OK),
    .KEY_CODE(KEY_CODE),
    .KEY_VALID(KEY_VALID),
    .KEY_READY(KEY_READY),
    .KEY_OVF(KEY_OVF),
    .KEY_OVF_CLR(KEY_OVF_CLR),
    .KB_IN(KB_IN), .KB_RECV(KB_RECV)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h cyc %0d",
               nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // reference model
  logic       h_send[$];
  logic       h_out[$];
  logic [1:0] m_q[$];
  logic [3:0] m_flags = 0;
  logic       m_valid = 0;
  bit         m_seen = 0;
  int         m_age = 0;
  int         m_n = 0;
  int         m_next = 0;
  logic [1:0] m_kb_in = 0;
  logic       m_kb_recv = 0;
  logic       m_ovf = 0;

  task automatic model_step();
    bit ok;
    bit was_full;
    if (!RST_N) begin
      h_send.delete();
      h_out.delete();
      m_q.delete();
      m_flags = 0; m_valid = 0;
      m_seen = 0; m_age = 0;
      m_n = 0; m_next = 0;
      m_kb_in = 0; m_kb_recv = 0;
      m_ovf = 0;
    end else begin
      m_n++;
      h_send.push_front(STATUS_SEND);
      h_out.push_front(STATUS_OUT);
      if (h_send.size() > FB + 1) begin
        void'(h_send.pop_back());
        void'(h_out.pop_back());
      end
      m_valid = 0;
      if (h_send.size() == FB + 1 && h_send[FB]) begin
        ok = 1;
        for (int i = 0; i < FB; i++)
          if (h_send[i]) ok = 0;
        if (ok) begin
          m_valid = 1;
          for (int i = 0; i < FB; i++)
            m_flags[i] = h_out[i];
        end
      end
      if (m_valid) begin
        m_age = 0;
        m_seen = 1;
      end else if (m_age < TO) begin
        m_age++;
      end
      was_full = (m_q.size() == DEPTH);
      if (KEY_OVF_CLR) m_ovf = 0;
      if (KEY_VALID) begin
        if (was_full) m_ovf = 1;
        else m_q.push_back(KEY_CODE);
      end
      m_kb_recv = 0;
      if (m_q.size() > 0 && m_n >= m_next) begin
        m_kb_in = m_q.pop_front();
        m_kb_recv = 1;
        m_next = m_n + GAP + 1;
      end
    end
  endtask

  initial forever begin
    @(posedge CLK or negedge RST_N);
    model_step();
  end

  // per-cycle comparison and event logging
  int n_valid = 0;
  int ready_low = 0;
  int st_t[$];
  int st_v[$];

  initial forever begin
    @(negedge CLK);
    if (chk_en) begin
      chk("flags", {ARMED, ALARM, SENSOR1, SENSOR2},
          m_flags);
      chk("status_valid", STATUS_VALID, m_valid);
      chk("link_ok", LINK_OK,
          m_seen && (m_age < TO));
      chk("key_ready", KEY_READY,
          m_q.size() < DEPTH);
      chk("key_ovf", KEY_OVF, m_ovf);
      chk("kb_recv", KB_RECV, m_kb_recv);
      chk("kb_in", KB_IN, m_kb_in);
    end
    if (RST_N && STATUS_VALID) n_valid++;
    if (RST_N && !KEY_READY) ready_low++;
    if (RST_N && KB_RECV) begin
      st_t.push_back(cyc);
      st_v.push_back(int'(KB_IN));
    end
  end

  task automatic send_frame(input logic [3:0] b);
    STATUS_SEND = 1;
    step();
    STATUS_SEND = 0;
    for (int i = FB - 1; i >= 0; i--) begin
      STATUS_OUT = b[i];
      step();
    end
    STATUS_OUT = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: sim time limit");
    $fatal(1, "timeout");
  end

  int p, n0, v0, r0;
  logic [1:0] ovf_seq [7] = '{1, 2, 3, 0, 1, 2, 3};

  initial begin
    step();
    step();
    chk_en = 1;
    step();
    chk("rst_flags",
        {ARMED, ALARM, SENSOR1, SENSOR2}, 0);
    chk("rst_link", LINK_OK, 0);
    chk("rst_ready", KEY_READY, 1);
    chk("rst_kb", {KB_IN, KB_RECV, KEY_OVF}, 0);
    RST_N = 1;
    step();

    // basic frame 1101
    send_frame(4'b1101);
    chk("f1_flags",
        {ARMED, ALARM, SENSOR1, SENSOR2}, 4'b1101);
    chk("f1_valid", STATUS_VALID, 1);
    chk("f1_link", LINK_OK, 1);
    step();
    chk("f1_pulse", STATUS_VALID, 0);

    // aborted frame then full frame 0010
    v0 = n_valid;
    STATUS_SEND = 1;
    step();
    STATUS_SEND = 0;
    STATUS_OUT = 1;
    step();
    STATUS_OUT = 0;
    step();
    send_frame(4'b0010);
    chk("ab_flags",
        {ARMED, ALARM, SENSOR1, SENSOR2}, 4'b0010);
    step();
    chk("ab_nvalid", n_valid - v0, 1);

    // link timeout
    repeat (62) step();
    chk("to_63", LINK_OK, 1);
    step();
    chk("to_64", LINK_OK, 0);
    send_frame(4'b1000);
    chk("to_back", LINK_OK, 1);

    // four digits alongside a status frame
    step();
    n0 = st_t.size();
    r0 = ready_low;
    p = cyc;
    fork
      send_frame(4'b0110);
      begin
        for (int i = 0; i < 4; i++) begin
          KEY_VALID = 1;
          KEY_CODE = 2'd1;
          step();
        end
        KEY_VALID = 0;
      end
    join
    repeat (8) step();
    chk("tx4_n", st_t.size() - n0, 4);
    for (int k = 0; k < 4; k++) begin
      if (n0 + k < st_t.size()) begin
        chk("tx4_t", st_t[n0+k] - p, 1 + 3 * k);
        chk("tx4_v", st_v[n0+k], 1);
      end
    end
    chk("tx4_ready", ready_low - r0, 0);
    chk("tx4_flags",
        {ARMED, ALARM, SENSOR1, SENSOR2}, 4'b0110);

    // overflow, set beats clear in the same cycle
    n0 = st_t.size();
    for (int i = 0; i < 7; i++) begin
      KEY_VALID = 1;
      KEY_CODE = ovf_seq[i];
      if (i == 6) begin
        chk("ovf_full", KEY_READY, 0);
        KEY_OVF_CLR = 1;
      end
      step();
    end
    KEY_VALID = 0;
    KEY_OVF_CLR = 0;
    chk("ovf_set", KEY_OVF, 1);
    repeat (20) step();
    chk("ovf_sticky", KEY_OVF, 1);
    chk("ovf_n", st_t.size() - n0, 6);
    for (int k = 0; k < 6; k++)
      if (n0 + k < st_t.size())
        chk("ovf_v", st_v[n0+k], int'(ovf_seq[k]));
    KEY_OVF_CLR = 1;
    step();
    KEY_OVF_CLR = 0;
    chk("ovf_clr", KEY_OVF, 0);

    // reset in the gap with two digits queued
    for (int i = 0; i < 3; i++) begin
      KEY_VALID = 1;
      KEY_CODE = (i == 0) ? 2'd3 : 2'd2;
      step();
    end
    KEY_VALID = 0;
    chk("gap_kb", KB_IN, 3);
    chk("gap_recv", KB_RECV, 0);
    RST_N = 0;
    #1;
    chk("mr_kb", {KB_IN, KB_RECV}, 0);
    chk("mr_ready", KEY_READY, 1);
    chk("mr_link", LINK_OK, 0);
    chk("mr_flags",
        {ARMED, ALARM, SENSOR1, SENSOR2}, 0);
    step();
    step();
    RST_N = 1;
    n0 = st_t.size();
    repeat (10) step();
    chk("mr_quiet", st_t.size() - n0, 0);
    KEY_VALID = 1;
    KEY_CODE = 2'd2;
    step();
    KEY_VALID = 0;
    chk("mr_new_recv", KB_RECV, 1);
    chk("mr_new_kb", KB_IN, 2);
    repeat (4) step();

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
